// File: rtl/lector_rom_pkg.sv
// Shared definitions for the ROM reader: state encoding and default widths.
package pkg_memorias;

    localparam int ANCHO_DIR  = 8;
    localparam int ANCHO_DATO = 8;
    localparam int ANCHO_SUMA = 16;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        LEER     = 2'd1,
        ENTREGAR = 2'd2,
        FIN      = 2'd3
    } estado_t;

endpackage

// File: rtl/lector_rom.sv
// Sequential ROM reader: walks an address range, streams each word over
// valid/ready, and accumulates the sum of the words delivered downstream.
module lector_rom #(
    parameter int ANCHO_DIR  = pkg_memorias::ANCHO_DIR,
    parameter int ANCHO_DATO = pkg_memorias::ANCHO_DATO,
    parameter int ANCHO_SUMA = pkg_memorias::ANCHO_SUMA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inicio,
    input  logic [ANCHO_DIR-1:0]  dir_base,
    input  logic [ANCHO_DIR-1:0]  cantidad,
    output logic [ANCHO_DIR-1:0]  direccion,
    input  logic [ANCHO_DATO-1:0] dato_s,
    output logic [ANCHO_DATO-1:0] dato_out,
    output logic                  valido,
    input  logic                  listo,
    output logic                  ocupado,
    output logic                  fin,
    output logic [ANCHO_SUMA-1:0] suma
);
    import pkg_memorias::*;

    estado_t               state_q, state_d;
    logic [ANCHO_DIR-1:0]  direccion_q, direccion_d;
    logic [ANCHO_DATO-1:0] dato_out_q, dato_out_d;
    logic                  valido_q, valido_d;
    logic [ANCHO_SUMA-1:0] suma_q, suma_d;
    logic [ANCHO_DIR-1:0]  restante_q, restante_d;

    logic handshake;
    assign handshake = valido_q && listo;

    // State and datapath registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= REPOSO;
            direccion_q <= '0;
            dato_out_q  <= '0;
            valido_q    <= 1'b0;
            suma_q      <= '0;
            restante_q  <= '0;
        end else begin
            state_q     <= state_d;
            direccion_q <= direccion_d;
            dato_out_q  <= dato_out_d;
            valido_q    <= valido_d;
            suma_q      <= suma_d;
            restante_q  <= restante_d;
        end
    end

    // Next-state logic; a zero-length request goes straight to FIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            REPOSO: begin
                if (inicio) begin
                    state_d = (cantidad == '0) ? FIN : LEER;
                end
            end
            LEER: begin
                state_d = ENTREGAR;
            end
            ENTREGAR: begin
                if (handshake) begin
                    state_d = (restante_q == ANCHO_DIR'(1)) ? FIN : LEER;
                end
            end
            FIN: begin
                state_d = REPOSO;
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    // Address, capture, remaining-count and accumulator updates per state.
    always_comb begin
        direccion_d = direccion_q;
        dato_out_d  = dato_out_q;
        valido_d    = valido_q;
        suma_d      = suma_q;
        restante_d  = restante_q;
        case (state_q)
            REPOSO: begin
                if (inicio) begin
                    direccion_d = dir_base;
                    restante_d  = cantidad;
                    suma_d      = '0;
                end
            end
            LEER: begin
                dato_out_d = dato_s;
                valido_d   = 1'b1;
            end
            ENTREGAR: begin
                if (handshake) begin
                    valido_d    = 1'b0;
                    suma_d      = suma_q + {{(ANCHO_SUMA-ANCHO_DATO){1'b0}}, dato_out_q};
                    direccion_d = direccion_q + ANCHO_DIR'(1);
                    restante_d  = restante_q - ANCHO_DIR'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Status outputs decoded directly from the current state.
    always_comb begin
        ocupado = (state_q != REPOSO);
        fin     = (state_q == FIN);
    end

    assign direccion = direccion_q;
    assign dato_out  = dato_out_q;
    assign valido    = valido_q;
    assign suma      = suma_q;

endmodule

// File: tb/tb_lector_rom.sv
// Self-checking bench for lector_rom with a behavioural 11-entry ROM beside it.
module tb_lector_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic        inicio;
    logic [7:0]  dir_base;
    logic [7:0]  cantidad;
    logic [7:0]  direccion;
    logic [7:0]  dato_s;
    logic [7:0]  dato_out;
    logic        valido;
    logic        listo;
    logic        ocupado;
    logic        fin;
    logic [15:0] suma;

    logic        modoIdent;
    int          testsRun;
    int          failCount;
    logic [7:0]  expQ[$];

    always #5 clk = ~clk;

    lector_rom dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .dir_base  (dir_base),
        .cantidad  (cantidad),
        .direccion (direccion),
        .dato_s    (dato_s),
        .dato_out  (dato_out),
        .valido    (valido),
        .listo     (listo),
        .ocupado   (ocupado),
        .fin       (fin),
        .suma      (suma)
    );

    // Team ROM contents; unpopulated addresses read as zero.
    function automatic logic [7:0] romTable(input logic [7:0] a);
        case (a)
            8'd0:    return 8'd90;
            8'd1:    return 8'd80;
            8'd2:    return 8'd70;
            8'd3:    return 8'd60;
            8'd4:    return 8'd50;
            8'd5:    return 8'd40;
            8'd6:    return 8'd30;
            8'd7:    return 8'd20;
            8'd8:    return 8'd10;
            8'd9:    return 8'd100;
            8'd10:   return 8'd101;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] romModel(input logic [7:0] a);
        return modoIdent ? a : romTable(a);
    endfunction

    // Combinational ROM, optionally replaced by an identity map for wrap tests.
    always_comb dato_s = modoIdent ? direccion : romTable(direccion);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        rst      = 1'b1;
        inicio   = 1'b0;
        listo    = 1'b0;
        dir_base = 8'd0;
        cantidad = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one transfer: pushes the expected words, drives the request and
    // listo pattern (stall cycles per word), and scores every handshake.
    task automatic applyStimulus(input logic [7:0] base, input logic [7:0] cant,
                                 input int stall, input string name);
        logic [15:0] expSum;
        logic [7:0]  a;
        int cycles, waitCnt, firstValido, finCount, ocupadoCnt, accepted, extras;
        bit done;
        expSum = '0;
        for (int i = 0; i < int'(cant); i++) begin
            a = base + 8'(i);
            expQ.push_back(romModel(a));
            expSum += {8'd0, romModel(a)};
        end
        @(negedge clk);
        dir_base = base;
        cantidad = cant;
        inicio   = 1'b1;
        listo    = (stall == 0);
        @(posedge clk);
        #1;
        inicio   = 1'b0;
        dir_base = 8'hAA;
        cantidad = 8'hAA;
        cycles = 0; waitCnt = 0; firstValido = -1; finCount = 0;
        ocupadoCnt = 0; accepted = 0; extras = 0; done = 1'b0;
        while (!done && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (ocupado) ocupadoCnt++;
            if (fin) finCount++;
            if (valido) begin
                if (firstValido < 0) firstValido = cycles;
                if (expQ.size() == 0) begin
                    extras++;
                    listo = 1'b1;
                end else begin
                    checkOutput({name, " dato_out"}, {24'd0, dato_out}, {24'd0, expQ[0]});
                    if (waitCnt >= stall) begin
                        listo = 1'b1;
                        void'(expQ.pop_front());
                        accepted++;
                    end else begin
                        listo = 1'b0;
                        waitCnt++;
                    end
                end
            end else begin
                listo   = (stall == 0);
                waitCnt = 0;
            end
            if (!ocupado) done = 1'b1;
        end
        checkOutput({name, " completed"}, {31'd0, done}, 32'd1);
        checkOutput({name, " fin pulses"}, 32'(finCount), 32'd1);
        checkOutput({name, " words"}, 32'(accepted), {24'd0, cant});
        checkOutput({name, " extra words"}, 32'(extras), 32'd0);
        checkOutput({name, " queue left"}, 32'(expQ.size()), 32'd0);
        checkOutput({name, " suma"}, {16'd0, suma}, {16'd0, expSum});
        checkOutput({name, " ocupado cycles"}, 32'(ocupadoCnt), 32'(int'(cant) * (2 + stall) + 1));
        if (cant != 8'd0)
            checkOutput({name, " valido latency"}, 32'(firstValido), 32'd2);
        else
            checkOutput({name, " valido never"}, 32'(firstValido), 32'hFFFF_FFFF);
        expQ.delete();
        listo = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   cycles, accepted;
        bit   sawFin;
        testsRun  = 0;
        failCount = 0;
        modoIdent = 1'b0;
        resetDut();

        checkOutput("reset direccion", {24'd0, direccion}, 32'd0);
        checkOutput("reset dato_out", {24'd0, dato_out}, 32'd0);
        checkOutput("reset valido", {31'd0, valido}, 32'd0);
        checkOutput("reset ocupado", {31'd0, ocupado}, 32'd0);
        checkOutput("reset fin", {31'd0, fin}, 32'd0);
        checkOutput("reset suma", {16'd0, suma}, 32'd0);

        applyStimulus(8'd0, 8'd3, 0, "basic");
        checkOutput("basic direccion hold", {24'd0, direccion}, 32'd3);

        applyStimulus(8'd8, 8'd3, 4, "backpressure");

        applyStimulus(8'd5, 8'd0, 0, "zero");
        checkOutput("zero direccion", {24'd0, direccion}, 32'd5);

        modoIdent = 1'b1;
        applyStimulus(8'd254, 8'd4, 0, "wrap");
        checkOutput("wrap direccion", {24'd0, direccion}, 32'd2);
        modoIdent = 1'b0;

        // Busy transfer with a stray inicio, then reset after two words.
        @(negedge clk);
        dir_base = 8'd0;
        cantidad = 8'd5;
        inicio   = 1'b1;
        listo    = 1'b1;
        @(posedge clk);
        #1;
        inicio   = 1'b0;
        cycles   = 0;
        accepted = 0;
        sawFin   = 1'b0;
        while (accepted < 2 && cycles < 50) begin
            @(negedge clk);
            cycles++;
            if (cycles == 3) begin
                inicio   = 1'b1;
                dir_base = 8'd8;
                cantidad = 8'd1;
            end else begin
                inicio = 1'b0;
            end
            if (fin) sawFin = 1'b1;
            if (valido && listo) begin
                checkOutput("busy dato_out", {24'd0, dato_out}, (accepted == 0) ? 32'd90 : 32'd80);
                accepted++;
            end
        end
        inicio = 1'b0;
        checkOutput("busy words before reset", 32'(accepted), 32'd2);
        @(negedge clk);
        if (fin) sawFin = 1'b1;
        checkOutput("busy suma", {16'd0, suma}, 32'd170);
        checkOutput("busy ocupado", {31'd0, ocupado}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort direccion", {24'd0, direccion}, 32'd0);
        checkOutput("abort dato_out", {24'd0, dato_out}, 32'd0);
        checkOutput("abort valido", {31'd0, valido}, 32'd0);
        checkOutput("abort ocupado", {31'd0, ocupado}, 32'd0);
        checkOutput("abort fin", {31'd0, fin}, 32'd0);
        checkOutput("abort suma", {16'd0, suma}, 32'd0);
        checkOutput("abort no fin seen", {31'd0, sawFin}, 32'd0);
        rst = 1'b0;

        applyStimulus(8'd4, 8'd1, 0, "post reset");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
